// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - switch-code lock with failed-attempt lockout and 7-seg/LED status
// Optional two-press code change with confirmation: define CODE_LOCK_CONFIRM_EN.
module code_lock_ctrl #(
    parameter int                CODE_W         = 10,
    parameter logic [CODE_W-1:0] RESET_CODE     = '0,
    parameter int                MAX_TRIES      = 3,
    parameter int                LOCKOUT_CYCLES = 250000000,
    parameter int                BLINK_BIT      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_check_n,
    input  logic              key_set_n,
    input  logic [CODE_W-1:0] sw,
    output logic [9:0]        led,
    output logic [7:0]        hex0,
    output logic [7:0]        hex1,
    output logic [7:0]        hex2,
    output logic [7:0]        hex3,
    output logic [7:0]        hex4
);

    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int TMR_W   = $clog2(LOCKOUT_CYCLES + 1);
    localparam int BLINK_W = BLINK_BIT + 1;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] SEG_E   = 8'b1000_0110;
    localparam logic [7:0] SEG_R   = 8'b1010_1111;
    localparam logic [7:0] SEG_O_L = 8'b1010_0011;
    localparam logic [7:0] SEG_S   = 8'b1001_0010;
    localparam logic [7:0] SEG_T   = 8'b1000_0111;
    localparam logic [7:0] SEG_L   = 8'b1100_0111;
    localparam logic [7:0] SEG_O_U = 8'b1100_0000;
    localparam logic [7:0] SEG_C   = 8'b1100_0110;
    localparam logic [7:0] SEG_DP  = 8'b0111_1111;

    typedef enum logic [2:0] {
        S_LOCKED,
        S_ERROR,
        S_OPEN,
        S_SET,
        S_LOCKOUT
`ifdef CODE_LOCK_CONFIRM_EN
        , S_CONFIRM
`endif
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   code;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [TMR_W-1:0]    timer;
    logic [BLINK_W-1:0]  blink_cnt;
`ifdef CODE_LOCK_CONFIRM_EN
    logic [CODE_W-1:0]   pend_code;
`endif

    // [0] metastability flop, [1] synchronised level, [2] previous level
    logic [2:0] chk_sr;
    logic [2:0] set_sr;
    logic       chk_p;
    logic       set_p;
    logic [FAIL_W:0] fail_nxt;

    assign chk_p    = chk_sr[2] & ~chk_sr[1];
    assign set_p    = set_sr[2] & ~set_sr[1];
    assign fail_nxt = {1'b0, fail_cnt} + (FAIL_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_sr <= 3'b111;
            set_sr <= 3'b111;
        end else begin
            chk_sr <= {chk_sr[1:0], key_check_n};
            set_sr <= {set_sr[1:0], key_set_n};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOCKED;
            code      <= RESET_CODE;
            fail_cnt  <= '0;
            timer     <= '0;
            blink_cnt <= '0;
`ifdef CODE_LOCK_CONFIRM_EN
            pend_code <= RESET_CODE;
`endif
            led       <= '0;
            hex0      <= SEG_OFF;
            hex1      <= SEG_OFF;
            hex2      <= SEG_OFF;
            hex3      <= SEG_OFF;
            hex4      <= SEG_OFF;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);

            // Display follows the state held before this edge
            led  <= '0;
            hex0 <= SEG_OFF;
            hex1 <= SEG_OFF;
            hex2 <= SEG_OFF;
            hex3 <= SEG_OFF;
            hex4 <= SEG_OFF;
            case (state)
                S_LOCKED: led <= {10{blink_cnt[BLINK_BIT]}};
                S_ERROR: begin
                    led  <= {10{blink_cnt[BLINK_BIT]}};
                    hex4 <= SEG_E;
                    hex3 <= SEG_R;
                    hex2 <= SEG_R;
                    hex1 <= SEG_O_L;
                    hex0 <= SEG_R;
                end
                S_OPEN: led <= 10'b00_0000_0011;
                S_SET: begin
                    hex2 <= SEG_S;
                    hex1 <= SEG_E;
                    hex0 <= SEG_T;
                end
                S_LOCKOUT: begin
                    led  <= '1;
                    hex4 <= SEG_L;
                    hex3 <= SEG_O_U;
                    hex2 <= SEG_C;
                end
`ifdef CODE_LOCK_CONFIRM_EN
                S_CONFIRM: begin
                    hex2 <= SEG_S & SEG_DP;
                    hex1 <= SEG_E & SEG_DP;
                    hex0 <= SEG_T & SEG_DP;
                end
`endif
                default: led <= '0;
            endcase

            if (state == S_LOCKOUT) begin
                if (timer != '0) begin
                    timer <= timer - TMR_W'(1);
                end
                if (timer <= TMR_W'(1)) begin
                    state    <= S_LOCKED;
                    fail_cnt <= '0;
                end
            end else if (chk_p ^ set_p) begin
                case (state)
                    S_LOCKED, S_ERROR: begin
                        if (set_p) begin
                            state <= S_ERROR;
                        end else if (sw == code) begin
                            state    <= S_OPEN;
                            fail_cnt <= '0;
                        end else if (fail_nxt >= (FAIL_W + 1)'(MAX_TRIES)) begin
                            state    <= S_LOCKOUT;
                            timer    <= TMR_W'(LOCKOUT_CYCLES);
                            fail_cnt <= FAIL_W'(MAX_TRIES);
                        end else begin
                            state    <= S_ERROR;
                            fail_cnt <= fail_nxt[FAIL_W-1:0];
                        end
                    end
                    S_OPEN, S_SET: begin
                        if (set_p) begin
`ifdef CODE_LOCK_CONFIRM_EN
                            pend_code <= sw;
                            state     <= S_CONFIRM;
`else
                            code      <= sw;
                            state     <= S_SET;
`endif
                        end else if (sw == code) begin
                            state <= S_OPEN;
                        end else begin
                            state    <= S_ERROR;
                            fail_cnt <= FAIL_W'(1);
                        end
                    end
`ifdef CODE_LOCK_CONFIRM_EN
                    S_CONFIRM: begin
                        if (set_p && sw == pend_code) begin
                            code  <= pend_code;
                            state <= S_SET;
                        end else begin
                            state <= S_OPEN;
                        end
                    end
`endif
                    default: state <= S_LOCKED;
                endcase
            end
        end
    end

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
- Parametrised successor of the DE10-Lite switch-code lock.
- Compares a CODE_W-bit switch code against a stored code. Tracks failed attempts and enters a timed lockout after MAX_TRIES consecutive failures. Allows the code to be changed only while unlocked.
- Drives five active-low 7-segment digits and ten LEDs. Sits directly between board buttons/switches and board displays.

Parameters:
- CODE_W, 10, width of switch code and stored code.
- RESET_CODE, 0, stored code after reset.
- MAX_TRIES, 3, consecutive failed checks that trigger lockout (>=1).
- LOCKOUT_CYCLES, 250000000, lockout duration in clk cycles (5 s at 50 MHz; >=1).
- BLINK_BIT, 24, free-running counter bit that drives LED blinking.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_check_n  in  1  "check code" button, active-low, asynchronous to clk.
- key_set_n  in  1  "set new code" button, active-low, asynchronous to clk.
- sw  in  CODE_W  code switches (level, sampled on the action cycle).
- led  out  10  status LEDs, active-high.
- hex0..hex4  out  8 each  7-seg digits, active-low, bit7 = decimal point.

Behaviour:
- Reset values: state=LOCKED, code=RESET_CODE, fail_cnt=0, lockout timer=0, blink counter=0, led=0, hex0..hex4=8'hFF. Reset is honoured in any state, including mid-lockout.
- Input conditioning:
  - Each key passes through a 2-flop synchroniser, then a falling-edge detector, giving a 1-cycle pulse (chk_p, set_p).
  - A held key produces exactly one pulse.
  - chk_p and set_p high in the same cycle: both are ignored, no state change.
- States: LOCKED, ERROR, OPEN, SET, LOCKOUT.
- Transitions (taken on the edge where the pulse is high):
  - LOCKED/ERROR, chk_p, sw==code: go to OPEN, fail_cnt=0.
  - LOCKED/ERROR, chk_p, mismatch: fail_cnt+1. If the new count == MAX_TRIES, go to LOCKOUT and load timer=LOCKOUT_CYCLES; otherwise go to ERROR.
  - LOCKED/ERROR, set_p: go to ERROR; fail_cnt unchanged.
  - OPEN/SET, set_p: code<=sw, go to SET. A repeated set_p re-captures the code.
  - OPEN/SET, chk_p, match: go to OPEN. Mismatch: go to ERROR with fail_cnt=1.
  - LOCKOUT: all pulses ignored; timer decrements each cycle. On the cycle the timer goes 1->0, go to LOCKED with fail_cnt=0.
- Blink counter: BLINK_BIT+1 bits, free-running, wraps silently.
- Outputs are registered and reflect the current state one cycle after the state register updates.
- Output decode by state:
  - LOCKED: hex all 8'hFF; led[9:0] all = blink bit.
  - ERROR: hex4..hex0 show "Error" = 10000110, 10101111, 10101111, 10100011, 10101111; led as LOCKED.
  - OPEN: hex all 8'hFF; led[1:0]=2'b11, others 0.
  - SET: hex2..hex0 show "SEt" = 10010010, 10000110, 10000111; hex4..hex3 8'hFF; led=0.
  - LOCKOUT: hex4..hex2 show "LOC" = 11000111, 11000000, 11000110; hex1..hex0 8'hFF; led all 1 steady.
- Width rules:
  - Comparison is full CODE_W equality.
  - fail_cnt width is $clog2(MAX_TRIES+1) and saturates at MAX_TRIES.
  - Timer width is $clog2(LOCKOUT_CYCLES+1).

Optional Feature:
- Macro: CODE_LOCK_CONFIRM_EN.
- Defined:
  - In OPEN/SET, set_p captures sw into pend_code and goes to CONFIRM.
  - CONFIRM shows "SEt" with decimal points lit (00010010, 00000110, 00000111) and led=0.
  - In CONFIRM, set_p with sw==pend_code: code<=pend_code, go to SET. set_p with mismatch: go to OPEN, code unchanged.
  - In CONFIRM, chk_p abandons the change and goes to OPEN.
- Undefined: single-press set as above; there is no CONFIRM state and no pend_code register.

Test Plan:
- Reset, sw=0, press check -> OPEN; one cycle later led=10'b0000000011 and all hex 8'hFF.
- From OPEN, sw=10'h2A5, press set -> SET showing "SEt", led=0. Relock via check with sw=0 -> ERROR showing "Error", LEDs blinking. Check with sw=10'h2A5 -> OPEN.
- Three wrong checks from LOCKED with MAX_TRIES=3, LOCKOUT_CYCLES=20 -> ERROR, ERROR, then LOCKOUT showing "LOC". Correct check during lockout is ignored. Exactly 20 cycles later -> LOCKED with fail_cnt=0.
- Hold key_check_n low for 1000 cycles -> exactly one chk_p and one transition. Both keys falling in the same cycle -> no state change.
- Assert rst for one cycle mid-LOCKOUT -> LOCKED, code=RESET_CODE, hex all 8'hFF, led=0.
- With CODE_LOCK_CONFIRM_EN: set 10'h155 then set 10'h154 -> OPEN and code unchanged. Set 10'h155 twice -> SET, and check with 10'h155 -> OPEN.
